// File: rtl/pipe_ctrl_chain.sv
// Elastic control/data pipeline with a combinational ready chain, per-stage
// kill mask, global stall, occupancy and a saturating flush counter.
module pipe_ctrl_chain #(
    parameter int                DEPTH    = 3,
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       flush_in,
    input  logic [DEPTH-1:0]           flush_mask,
    input  logic                       stall_all,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [7:0]                 flush_count
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [OCC_W-1:0]             occupancy_q, occupancy_d;
    logic [7:0]                   flush_count_q, flush_count_d;

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] kill;
    logic [8:0]       flush_sum;

    // Ready chain: a stage is free if empty (or killed) or its successor moves.
    always_comb begin
        live = v_q & ~flush_mask;
        free = '0;
        free[DEPTH-1] = ~live[DEPTH-1] | (out_ready & ~stall_all);
        for (int i = DEPTH-2; i >= 0; i--) begin
            free[i] = ~live[i] | (free[i+1] & ~stall_all);
        end
        adv = free & {DEPTH{~stall_all}};
    end

    always_comb begin
        v_d    = v_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        for (int i = DEPTH-1; i >= 1; i--) begin
            if (adv[i]) begin
                v_d[i]    = live[i-1];
                ctrl_d[i] = ctrl_q[i-1];
                data_d[i] = data_q[i-1];
            end else begin
                v_d[i] = live[i];
            end
        end
        if (adv[0]) begin
            v_d[0] = in_valid & ~flush_in;
            if (in_valid) begin
                ctrl_d[0] = in_ctrl;
                data_d[0] = in_data;
            end
        end else begin
            v_d[0] = live[0];
        end

        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(v_d[i]);
        end

        kill      = v_q & flush_mask;
        flush_sum = {1'b0, flush_count_q};
        for (int i = 0; i < DEPTH; i++) begin
            flush_sum = flush_sum + 9'(kill[i]);
        end
        flush_count_d = (flush_sum > 9'd255) ? 8'd255 : flush_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q           <= '0;
            ctrl_q        <= {DEPTH{NOP_CTRL}};
            data_q        <= '0;
            occupancy_q   <= '0;
            flush_count_q <= '0;
        end else begin
            v_q           <= v_d;
            ctrl_q        <= ctrl_d;
            data_q        <= data_d;
            occupancy_q   <= occupancy_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        in_ready    = adv[0];
        out_valid   = live[DEPTH-1] & ~stall_all;
        out_ctrl    = out_valid ? ctrl_q[DEPTH-1] : NOP_CTRL;
        out_data    = out_valid ? data_q[DEPTH-1] : '0;
        occupancy   = occupancy_q;
        flush_count = flush_count_q;
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench for pipe_ctrl_chain: slot-array reference model predicts
// handshakes and counters; a monitor pops expected beats as the DUT retires them.
module tb_pipe_ctrl_chain;

    localparam int        DEPTH = 3;
    localparam int        CW    = 8;
    localparam int        DW    = 16;
    localparam logic [CW-1:0] NOP = 8'hA5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [CW-1:0]    in_ctrl = '0;
    logic [DW-1:0]    in_data = '0;
    logic             flush_in = 1'b0;
    logic [DEPTH-1:0] flush_mask = '0;
    logic             stall_all = 1'b0;
    logic             out_valid, out_ready = 1'b0;
    logic [CW-1:0]    out_ctrl;
    logic [DW-1:0]    out_data;
    logic [1:0]       occupancy;
    logic [7:0]       flush_count;

    pipe_ctrl_chain #(.DEPTH(DEPTH), .CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(NOP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush_in(flush_in),
        .flush_mask(flush_mask), .stall_all(stall_all), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference: which slot holds which beat; entries move toward the output.
    bit    mv[DEPTH];
    beat_t mb[DEPTH];
    int    mfc = 0;
    logic [DW-1:0] seq = 16'h0100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        mfc = 0;
        exp_q.delete();
    endtask

    task automatic drop_expected(input beat_t b);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k] == b) begin
                exp_q.delete(k);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        bit    lv[DEPTH];
        bit    fr[DEPTH];
        bit    nv[DEPTH];
        beat_t nb[DEPTH];
        int    cnt;
        bit    go;
        if (!rst) begin
            go  = !stall_all;
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) begin
                lv[i] = mv[i] && !flush_mask[i];
                cnt += int'(mv[i]);
            end
            fr[DEPTH-1] = !lv[DEPTH-1] || (out_ready && go);
            for (int i = DEPTH-2; i >= 0; i--) fr[i] = !lv[i] || (fr[i+1] && go);

            check("in_ready", in_ready, fr[0] && go);
            check("out_valid", out_valid, lv[DEPTH-1] && go);
            check("occupancy", occupancy, cnt);
            check("flush_count", flush_count, mfc);

            for (int i = 0; i < DEPTH; i++) begin
                if (mv[i] && flush_mask[i]) begin
                    if (mfc < 255) mfc++;
                    drop_expected(mb[i]);
                end
            end
            for (int i = DEPTH-1; i >= 1; i--) begin
                nv[i] = (fr[i] && go) ? lv[i-1] : lv[i];
                nb[i] = (fr[i] && go) ? mb[i-1] : mb[i];
            end
            if (fr[0] && go) begin
                nv[0] = in_valid && !flush_in;
                nb[0] = {in_ctrl, in_data};
                if (nv[0]) exp_q.push_back({in_ctrl, in_data});
            end else begin
                nv[0] = lv[0];
                nb[0] = mb[0];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] = nv[i];
                mb[i] = nb[i];
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(exp_q.size()), 1);
                end else begin
                    b = exp_q.pop_front();
                    check("out_ctrl", out_ctrl, b.c);
                    check("out_data", out_data, b.d);
                end
            end else if (!out_valid) begin
                check("idle_ctrl", out_ctrl, NOP);
                check("idle_data", out_data, 0);
            end
        end
    end

    task automatic step(input bit iv, input bit fi, input logic [DEPTH-1:0] fm,
                        input bit st, input bit ord);
        in_valid   = iv;
        flush_in   = fi;
        flush_mask = fm;
        stall_all  = st;
        out_ready  = ord;
        in_ctrl    = CW'($urandom);
        in_data    = seq;
        seq        = seq + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, 0, 1);
    endtask

    initial begin
        int fc_before;
        model_reset();
        #12;
        check("rst_occupancy", occupancy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, NOP);
        check("rst_out_data", out_data, 0);
        check("rst_flush_count", flush_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A,B,C back to back
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 1);
        check("occ_peak", occupancy, 3);
        drain(5);

        // full chain under backpressure, then release
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, '0, 0, 0);
        check("bp_occupancy", occupancy, 3);
        drain(5);

        // kill stages 0 and 1 together
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 0);
        fc_before = int'(flush_count);
        step(0, 0, 3'b011, 0, 0);
        check("mask_occupancy", occupancy, 1);
        check("mask_flush_count", flush_count, fc_before + 2);
        drain(5);

        // global stall with traffic pending
        for (int k = 0; k < 2; k++) step(1, 0, '0, 0, 0);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 0, 1);
        drain(5);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end
        drain(5);

        // saturate the flush counter
        for (int k = 0; k < 300; k++) begin
            step(1, 0, '0, 0, 1);
            step(0, 0, 3'b001, 0, 1);
        end
        check("flush_sat", flush_count, 255);
        step(1, 0, '0, 0, 1);
        step(0, 0, 3'b001, 0, 1);
        check("flush_sat_hold", flush_count, 255);
        drain(4);

        // reset between edges with two beats held
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_occupancy", occupancy, 0);
        model_reset();
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        step(1, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        check("post_rst_latency", out_valid, 1);
        drain(6);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
